adder_arbiter: RTL and testbench
================================

# adder_arbiter

Shares a single signed 2-input adder between N_REQ requesters (neuron/gradient units in the ANN datapath) using round-robin arbitration and a valid/ready result handshake. Each accepted request produces one registered sum tagged with the requester index and a signed-overflow flag. The block sits between the per-neuron control logic and the shared arithmetic resource, replacing per-unit adders where area matters.

## Interface

Parameters:
- WIDTH, 32, operand and result width (signed two's complement)
- N_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of requester index; must equal ceil(log2(N_REQ)), minimum 1

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset; synchronous, active-low
- i_req  input  N_REQ  request per requester; bit k held high with operands stable until o_gnt[k] pulses
- i_a  input  N_REQ*WIDTH  operand A, requester k at bits [k*WIDTH +: WIDTH]
- i_b  input  N_REQ*WIDTH  operand B, same packing
- o_gnt  output  N_REQ  one-hot (or zero) accept strobe, combinational, same cycle as acceptance
- o_valid  output  1  result register holds an unconsumed result
- i_ready  input  1  downstream consumes result when o_valid && i_ready
- o  output  WIDTH  registered sum
- o_id  output  ID_W  index of requester that produced o
- o_ovf  output  1  signed overflow of the sum in o

## Operation

- accept = (|i_req) && (!o_valid || i_ready); rst low forces accept = 0 and o_gnt = 0.
- Round-robin pointer ptr (ID_W bits): winner k = first requester with i_req set searching ptr, ptr+1, ..., wrapping at N_REQ-1 → 0.
- o_gnt[k] = accept for the winner only; all other bits 0.
- On an accepting edge: o <= i_a[k] + i_b[k] (modulo 2^WIDTH, wrap, no saturation); o_id <= k; o_ovf <= (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]); o_valid <= 1; ptr <= (k==N_REQ-1) ? 0 : k+1.
- No accept, o_valid && i_ready: o_valid <= 0; o, o_id, o_ovf hold last values.
- No accept, o_valid && !i_ready: all outputs hold (stall); ptr holds.
- Consume and accept in same cycle: new result replaces old with o_valid staying 1 (full throughput, one result per cycle).
- ptr only moves on accept; a requester left waiting is served within N_REQ-1 further accepts.
- Requester dropping i_req before grant is legal; request is simply withdrawn.
- Reset values: o_valid 0, o 0, o_id 0, o_ovf 0, ptr 0. Reset mid-operation discards any held result and resets priority to requester 0.

## Timing

- Grant: combinational, cycle of request presentation (zero-cycle arbitration latency when not stalled).
- Result: o_valid high from the edge ending the grant cycle; latency 1 cycle.
- Throughput: 1 result/cycle with i_ready held high.
- Backpressure: with o_valid=1 and i_ready=0, o_gnt is 0 and no request is accepted until i_ready returns.
- Critical path: i_req/ptr → priority select → operand mux → WIDTH-bit add → register.

## Test plan

- Reset: rst low 2 cycles with all i_req=1 → o_gnt=0, o_valid=0, o=0, o_id=0, o_ovf=0; first cycle after release grants requester 0.
- Single requester: N_REQ=4, i_req=4'b0100, a=5, b=-7, i_ready=1 → o_gnt=4'b0100 same cycle; next cycle o_valid=1, o=-2, o_id=2, o_ovf=0; ptr=3.
- Round-robin fairness: i_req=4'b1111 held, i_ready=1, 8 cycles → grant order 0,1,2,3,0,1,2,3, one result per cycle with matching o_id.
- Backpressure: result valid, i_ready=0 for 3 cycles with i_req=4'b0011 → o_gnt=0, o/o_id/o_ovf stable for 3 cycles; i_ready=1 → same-cycle consume and grant of next requester.
- Overflow/wrap: WIDTH=32, a=0x7FFFFFFF, b=1 → o=0x80000000, o_ovf=1; a=0x80000000, b=0xFFFFFFFF → o=0x7FFFFFFF, o_ovf=1; a=-1, b=1 → o=0, o_ovf=0.
- Reset mid-operation: o_valid=1, ptr=2, rst low 1 cycle with i_ready=0 → o_valid=0; after release with i_req=4'b1111, requester 0 granted first.

Source files
------------

// File: rtl/adder_arbiter_if.sv
// Request/result bundle between the requesters and the shared signed adder.
// The master modport is the requester/consumer side; the slave is the arbiter.
interface adder_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]       i_req;
    logic [N_REQ*WIDTH-1:0] i_a;
    logic [N_REQ*WIDTH-1:0] i_b;
    logic [N_REQ-1:0]       o_gnt;
    logic                   o_valid;
    logic                   i_ready;
    logic [WIDTH-1:0]       o;
    logic [ID_W-1:0]        o_id;
    logic                   o_ovf;

    modport master (
        output i_req, i_a, i_b, i_ready,
        input  o_gnt, o_valid, o, o_id, o_ovf
    );

    modport slave (
        input  i_req, i_a, i_b, i_ready,
        output o_gnt, o_valid, o, o_id, o_ovf
    );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one signed WIDTH-bit adder among N_REQ requesters.
// One registered, tagged sum per accept; valid/ready result handshake with full throughput.
module adder_arbiter #(
    parameter int WIDTH = 32,
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic            clk,
    input  logic            rst,
    adder_arbiter_if.slave  bus
);

    logic signed [WIDTH-1:0] a_arr [N_REQ];
    logic signed [WIDTH-1:0] b_arr [N_REQ];

    logic                    valid_reg, valid_next;
    logic [WIDTH-1:0]        o_reg, o_next;
    logic [ID_W-1:0]         id_reg, id_next;
    logic                    ovf_reg, ovf_next;
    logic [ID_W-1:0]         ptr_reg, ptr_next;

    logic                    win_found;
    logic [ID_W-1:0]         win_idx;
    logic                    accept;
    logic signed [WIDTH-1:0] a_sel;
    logic signed [WIDTH-1:0] b_sel;
    logic signed [WIDTH-1:0] sum;
    logic                    sum_ovf;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = bus.i_a[gi*WIDTH +: WIDTH];
            assign b_arr[gi] = bus.i_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Search starts at ptr and wraps, so the requester just served has lowest priority.
    always_comb begin
        int k;
        logic [ID_W-1:0] k_idx;
        win_found = 1'b0;
        win_idx   = '0;
        k         = 0;
        k_idx     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            k = int'(ptr_reg) + i;
            if (k >= N_REQ) begin
                k = k - N_REQ;
            end
            k_idx = ID_W'(k);
            if (!win_found && bus.i_req[k_idx]) begin
                win_found = 1'b1;
                win_idx   = k_idx;
            end
        end
    end

    assign accept = rst && win_found && (!valid_reg || bus.i_ready);

    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_gnt
            assign bus.o_gnt[gi] = accept && (win_idx == ID_W'(gi));
        end
    endgenerate

    assign a_sel   = a_arr[win_idx];
    assign b_sel   = b_arr[win_idx];
    assign sum     = a_sel + b_sel;
    // Overflow only when both operands share a sign that the sum does not.
    assign sum_ovf = (a_sel[WIDTH-1] == b_sel[WIDTH-1]) && (sum[WIDTH-1] != a_sel[WIDTH-1]);

    always_comb begin
        valid_next = valid_reg;
        o_next     = o_reg;
        id_next    = id_reg;
        ovf_next   = ovf_reg;
        ptr_next   = ptr_reg;
        if (accept) begin
            valid_next = 1'b1;
            o_next     = sum;
            id_next    = win_idx;
            ovf_next   = sum_ovf;
            ptr_next   = (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
        end else if (valid_reg && bus.i_ready) begin
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_reg <= 1'b0;
            o_reg     <= '0;
            id_reg    <= '0;
            ovf_reg   <= 1'b0;
            ptr_reg   <= '0;
        end else begin
            valid_reg <= valid_next;
            o_reg     <= o_next;
            id_reg    <= id_next;
            ovf_reg   <= ovf_next;
            ptr_reg   <= ptr_next;
        end
    end

    assign bus.o_valid = valid_reg;
    assign bus.o       = o_reg;
    assign bus.o_id    = id_reg;
    assign bus.o_ovf   = ovf_reg;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed scenarios plus randomized traffic
// compared against a round-robin/arithmetic reference model.
module tb_adder_arbiter;

    localparam int WIDTH = 32;
    localparam int N_REQ = 4;
    localparam int ID_W  = 2;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    adder_arbiter_if #(.WIDTH(WIDTH), .N_REQ(N_REQ), .ID_W(ID_W)) bus ();

    adder_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: a rotating priority position plus a one-entry result slot.
    int          m_ptr   = 0;
    logic        m_valid = 1'b0;
    logic [31:0] m_o     = '0;
    int          m_id    = 0;
    logic        m_ovf   = 1'b0;

    function automatic int m_winner();
        for (int i = 0; i < N_REQ; i++) begin
            int k;
            k = (m_ptr + i) % N_REQ;
            if (bus.i_req[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [3:0] m_gnt();
        int w;
        w = m_winner();
        if (!rst || w < 0 || (m_valid && !bus.i_ready)) return 4'b0000;
        return 4'(1 << w);
    endfunction

    function automatic logic m_ovf_of(input logic [31:0] a, input logic [31:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
        return (s > MAXV) || (s < MINV);
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_valid <= 1'b0;
            m_o     <= '0;
            m_id    <= 0;
            m_ovf   <= 1'b0;
            m_ptr   <= 0;
        end else if (m_winner() >= 0 && (!m_valid || bus.i_ready)) begin
            m_valid <= 1'b1;
            m_o     <= bus.i_a[m_winner()*WIDTH +: WIDTH] + bus.i_b[m_winner()*WIDTH +: WIDTH];
            m_ovf   <= m_ovf_of(bus.i_a[m_winner()*WIDTH +: WIDTH], bus.i_b[m_winner()*WIDTH +: WIDTH]);
            m_id    <= m_winner();
            m_ptr   <= (m_winner() + 1) % N_REQ;
        end else if (m_valid && bus.i_ready) begin
            m_valid <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int k, input logic [31:0] a, input logic [31:0] b);
        bus.i_a[k*WIDTH +: WIDTH] = a;
        bus.i_b[k*WIDTH +: WIDTH] = b;
    endtask

    task automatic test_reset();
        rst         = 1'b0;
        bus.i_req   = 4'b1111;
        bus.i_ready = 1'b1;
        bus.i_a     = '0;
        bus.i_b     = '0;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (bus.o_gnt !== 4'b0000) begin
                failures++;
                $display("FAIL reset_gnt cycle=%0d got=%b exp=0000", c, bus.o_gnt);
            end
            tick();
            checks++;
            if ({bus.o_valid, bus.o, bus.o_id, bus.o_ovf} !== '0) begin
                failures++;
                $display("FAIL reset_outputs got valid=%b o=%h id=%0d ovf=%b exp all zero",
                         bus.o_valid, bus.o, bus.o_id, bus.o_ovf);
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.o_gnt !== 4'b0001) begin
            failures++;
            $display("FAIL reset_release_gnt got=%b exp=0001", bus.o_gnt);
        end
        tick();
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_id !== 2'd0) begin
            failures++;
            $display("FAIL reset_release_result got valid=%b id=%0d exp valid=1 id=0", bus.o_valid, bus.o_id);
        end
        $display("test_reset done");
    endtask

    task automatic test_single();
        bus.i_req   = 4'b0100;
        bus.i_ready = 1'b1;
        set_op(2, 32'd5, -32'sd7);
        #1;
        checks++;
        if (bus.o_gnt !== 4'b0100) begin
            failures++;
            $display("FAIL single_gnt got=%b exp=0100", bus.o_gnt);
        end
        tick();
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o !== 32'hFFFF_FFFE || bus.o_id !== 2'd2 || bus.o_ovf !== 1'b0) begin
            failures++;
            $display("FAIL single_result got valid=%b o=%h id=%0d ovf=%b exp valid=1 o=fffffffe id=2 ovf=0",
                     bus.o_valid, bus.o, bus.o_id, bus.o_ovf);
        end
        bus.i_req = 4'b1111;
        #1;
        checks++;
        if (bus.o_gnt !== 4'b1000) begin
            failures++;
            $display("FAIL single_ptr_next got=%b exp=1000", bus.o_gnt);
        end
        tick();
        $display("test_single done");
    endtask

    task automatic test_round_robin();
        logic [31:0] a, b;
        bus.i_req   = 4'b1111;
        bus.i_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            a = $urandom;
            b = $urandom;
            set_op(c % 4, a, b);
            #1;
            checks++;
            if (bus.o_gnt !== 4'(1 << (c % 4))) begin
                failures++;
                $display("FAIL rr_gnt cycle=%0d got=%b exp=%b", c, bus.o_gnt, 4'(1 << (c % 4)));
            end
            tick();
            checks++;
            if (bus.o_valid !== 1'b1 || bus.o_id !== 2'(c % 4) || bus.o !== a + b) begin
                failures++;
                $display("FAIL rr_result cycle=%0d got valid=%b id=%0d o=%h exp valid=1 id=%0d o=%h",
                         c, bus.o_valid, bus.o_id, bus.o, c % 4, a + b);
            end
        end
        $display("test_round_robin done");
    endtask

    task automatic test_backpressure();
        bus.i_req   = 4'b0011;
        bus.i_ready = 1'b1;
        set_op(0, 32'd100, 32'd200);
        set_op(1, 32'd7, 32'd8);
        #1;
        checks++;
        if (bus.o_gnt !== 4'b0001) begin
            failures++;
            $display("FAIL bp_first_gnt got=%b exp=0001", bus.o_gnt);
        end
        tick();
        bus.i_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (bus.o_gnt !== 4'b0000) begin
                failures++;
                $display("FAIL bp_stall_gnt cycle=%0d got=%b exp=0000", c, bus.o_gnt);
            end
            tick();
            checks++;
            if (bus.o_valid !== 1'b1 || bus.o !== 32'd300 || bus.o_id !== 2'd0 || bus.o_ovf !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d got valid=%b o=%h id=%0d ovf=%b exp valid=1 o=12c id=0 ovf=0",
                         c, bus.o_valid, bus.o, bus.o_id, bus.o_ovf);
            end
        end
        bus.i_ready = 1'b1;
        #1;
        checks++;
        if (bus.o_gnt !== 4'b0010) begin
            failures++;
            $display("FAIL bp_resume_gnt got=%b exp=0010", bus.o_gnt);
        end
        tick();
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o !== 32'd15 || bus.o_id !== 2'd1) begin
            failures++;
            $display("FAIL bp_resume_result got valid=%b o=%h id=%0d exp valid=1 o=f id=1",
                     bus.o_valid, bus.o, bus.o_id);
        end
        $display("test_backpressure done");
    endtask

    task automatic test_overflow();
        logic [31:0] ta [3];
        logic [31:0] tb [3];
        logic [31:0] to [3];
        logic        tv [3];
        ta = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        tb = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001};
        to = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000};
        tv = '{1'b1, 1'b1, 1'b0};
        bus.i_req   = 4'b0001;
        bus.i_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            set_op(0, ta[c], tb[c]);
            #1;
            checks++;
            if (bus.o_gnt !== 4'b0001) begin
                failures++;
                $display("FAIL ovf_gnt case=%0d got=%b exp=0001", c, bus.o_gnt);
            end
            tick();
            checks++;
            if (bus.o !== to[c] || bus.o_ovf !== tv[c]) begin
                failures++;
                $display("FAIL ovf_result case=%0d got o=%h ovf=%b exp o=%h ovf=%b",
                         c, bus.o, bus.o_ovf, to[c], tv[c]);
            end
        end
        $display("test_overflow done");
    endtask

    task automatic test_reset_mid();
        bus.i_req   = 4'b0010;
        bus.i_ready = 1'b1;
        set_op(1, 32'd1, 32'd2);
        #1;
        tick();
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_id !== 2'd1) begin
            failures++;
            $display("FAIL midrst_setup got valid=%b id=%0d exp valid=1 id=1", bus.o_valid, bus.o_id);
        end
        bus.i_ready = 1'b0;
        bus.i_req   = 4'b1111;
        rst         = 1'b0;
        #1;
        tick();
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o !== 32'd0) begin
            failures++;
            $display("FAIL midrst_clear got valid=%b o=%h exp valid=0 o=0", bus.o_valid, bus.o);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.o_gnt !== 4'b0001) begin
            failures++;
            $display("FAIL midrst_first_gnt got=%b exp=0001", bus.o_gnt);
        end
        tick();
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst         = ($urandom_range(0, 39) != 0);
            bus.i_req   = 4'($urandom);
            bus.i_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < N_REQ; k++) begin
                if ($urandom_range(0, 3) == 0) set_op(k, 32'h7FFF_FFF0 + 32'($urandom_range(0, 31)), $urandom);
                else                           set_op(k, $urandom, $urandom);
            end
            #1;
            checks++;
            if (bus.o_gnt !== m_gnt()) begin
                failures++;
                $display("FAIL rand_gnt cycle=%0d got=%b exp=%b", c, bus.o_gnt, m_gnt());
            end
            tick();
            checks++;
            if (bus.o_valid !== m_valid || bus.o !== m_o || bus.o_id !== 2'(m_id) || bus.o_ovf !== m_ovf) begin
                failures++;
                $display("FAIL rand_result cycle=%0d got valid=%b o=%h id=%0d ovf=%b exp valid=%b o=%h id=%0d ovf=%b",
                         c, bus.o_valid, bus.o, bus.o_id, bus.o_ovf, m_valid, m_o, m_id, m_ovf);
            end
        end
        rst = 1'b1;
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
